// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multi-cycle MIPS datapath: decodes op_code/funct into selects and strobes.
// Latency: lw 5, R/addi/sw 4, beq/j/jal/jr 3 cycles; mem_ready=0 stalls FETCH, MEM_RD and MEM_WR.
// Define INSTR_COUNT_EN to build the retired-instruction counter on instr_count (tied to 0 otherwise).
module multicycle_control_fsm #(
   parameter logic [5:0] OP_RTYPE = 6'h00,
   parameter logic [5:0] OP_LW    = 6'h23,
   parameter logic [5:0] OP_SW    = 6'h2B,
   parameter logic [5:0] OP_BEQ   = 6'h04,
   parameter logic [5:0] OP_J     = 6'h02,
   parameter logic [5:0] OP_JAL   = 6'h03,
   parameter logic [5:0] OP_ADDI  = 6'h08,
   parameter logic [5:0] FUNCT_JR = 6'h08
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  op_code,
   input  logic [5:0]  funct,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        reg_write,
   output logic [1:0]  reg_dst,
   output logic [1:0]  mem_to_reg,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_source,
   output logic        arith,
   output logic        illegal_op,
   output logic [3:0]  state,
   output logic [31:0] instr_count
);

   localparam logic [3:0] FETCH    = 4'd0,  DECODE = 4'd1,  MEM_ADDR = 4'd2,  MEM_RD = 4'd3,
                          MEM_WB   = 4'd4,  MEM_WR = 4'd5,  EXEC_R   = 4'd6,  R_WB   = 4'd7,
                          BRANCH   = 4'd8,  JUMP   = 4'd9,  I_EXEC   = 4'd10, I_WB   = 4'd11,
                          JAL      = 4'd12, JR     = 4'd13;

   logic [3:0] state_q;
   logic [3:0] state_nxt;
   logic [3:0] decode_nxt;
   logic       op_legal;

   always_comb begin
      op_legal   = 1'b1;
      decode_nxt = FETCH;
      case (op_code)
         OP_LW, OP_SW: decode_nxt = MEM_ADDR;
         OP_RTYPE:     decode_nxt = (funct == FUNCT_JR) ? JR : EXEC_R;
         OP_BEQ:       decode_nxt = BRANCH;
         OP_J:         decode_nxt = JUMP;
         OP_JAL:       decode_nxt = JAL;
         OP_ADDI:      decode_nxt = I_EXEC;
         default:      op_legal   = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = FETCH;
      case (state_q)
         FETCH:    state_nxt = mem_ready ? DECODE : FETCH;
         DECODE:   state_nxt = decode_nxt;
         MEM_ADDR: state_nxt = (op_code == OP_SW) ? MEM_WR : MEM_RD;
         MEM_RD:   state_nxt = mem_ready ? MEM_WB : MEM_RD;
         MEM_WR:   state_nxt = mem_ready ? FETCH : MEM_WR;
         EXEC_R:   state_nxt = R_WB;
         I_EXEC:   state_nxt = I_WB;
         default:  state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_nxt;
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 2'd0;
      mem_to_reg    = 2'd0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      alu_op        = 2'd0;
      pc_source     = 2'd0;
      illegal_op    = 1'b0;
      case (state_q)
         FETCH:    begin mem_read = 1'b1; alu_src_b = 2'd1; ir_write = mem_ready; pc_write = mem_ready; end
         DECODE:   begin alu_src_b = 2'd3; illegal_op = ~op_legal; end
         MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'd2; end
         MEM_RD:   begin mem_read = 1'b1; i_or_d = 1'b1; end
         MEM_WB:   begin reg_write = 1'b1; mem_to_reg = 2'd1; end
         MEM_WR:   begin mem_write = 1'b1; i_or_d = 1'b1; end
         EXEC_R:   begin alu_src_a = 1'b1; alu_op = 2'd2; end
         R_WB:     begin reg_write = 1'b1; reg_dst = 2'd1; end
         BRANCH:   begin alu_src_a = 1'b1; alu_op = 2'd1; pc_write_cond = 1'b1; pc_source = 2'd1; end
         JUMP:     begin pc_write = 1'b1; pc_source = 2'd2; end
         JAL:      begin pc_write = 1'b1; pc_source = 2'd2; reg_write = 1'b1; reg_dst = 2'd2; mem_to_reg = 2'd2; end
         JR:       begin pc_write = 1'b1; pc_source = 2'd3; end
         I_EXEC:   begin alu_src_a = 1'b1; alu_src_b = 2'd2; end
         I_WB:     reg_write = 1'b1;
         default:  ;
      endcase
      // Strobes are squashed combinationally so an in-flight write dies in the reset cycle itself.
      if (reset) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         reg_write     = 1'b0;
         illegal_op    = 1'b0;
      end
   end

   assign arith = 1'b1;
   assign state = state_q;

`ifdef INSTR_COUNT_EN
   logic [31:0] count_q;
   logic        retire;

   always_comb begin
      retire = 1'b0;
      case (state_q)
         MEM_WB, R_WB, BRANCH, JUMP, JAL, JR, I_WB: retire = 1'b1;
         MEM_WR:                                    retire = mem_ready;
         default:                                   retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)       count_q <= 32'h0;
      else if (retire) count_q <= count_q + 32'd1;
   end

   assign instr_count = count_q;
`else
   assign instr_count = 32'h0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed and random instructions against a per-instruction phase model.
module tb_multicycle_control_fsm;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04,
                          OP_J = 6'h02, OP_JAL = 6'h03, OP_ADDI = 6'h08, FUNCT_JR = 6'h08;

   localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_RD = 3, S_MEM_WB = 4,
                  S_MEM_WR = 5, S_EXEC_R = 6, S_R_WB = 7, S_BRANCH = 8, S_JUMP = 9,
                  S_I_EXEC = 10, S_I_WB = 11, S_JAL = 12, S_JR = 13;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       arith;
      logic       illegal_op;
      logic [3:0] state;
   } ctl_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  op_code;
   logic [5:0]  funct;
   logic        mem_ready;
   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write;
   logic [1:0]  reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
   logic        alu_src_a, arith, illegal_op;
   logic [3:0]  state;
   logic [31:0] instr_count;

   ctl_t        obs;
   logic [31:0] exp_count;
   int          checks = 0;
   int          failures = 0;

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset), .op_code(op_code), .funct(funct), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .pc_source(pc_source), .arith(arith), .illegal_op(illegal_op),
      .state(state), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write,
                 reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, arith,
                 illegal_op, state};

   // Control word each phase of an instruction must present, read straight off the state table.
   function automatic ctl_t expect_ctl(input int ph, input logic mr, input logic ill);
      ctl_t c;
      c       = '0;
      c.arith = 1'b1;
      c.state = 4'(ph);
      case (ph)
         S_FETCH:    begin c.mem_read = 1; c.alu_src_b = 2'd1; c.ir_write = mr; c.pc_write = mr; end
         S_DECODE:   begin c.alu_src_b = 2'd3; c.illegal_op = ill; end
         S_MEM_ADDR: begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
         S_MEM_RD:   begin c.mem_read = 1; c.i_or_d = 1; end
         S_MEM_WB:   begin c.reg_write = 1; c.mem_to_reg = 2'd1; end
         S_MEM_WR:   begin c.mem_write = 1; c.i_or_d = 1; end
         S_EXEC_R:   begin c.alu_src_a = 1; c.alu_op = 2'd2; end
         S_R_WB:     begin c.reg_write = 1; c.reg_dst = 2'd1; end
         S_BRANCH:   begin c.alu_src_a = 1; c.alu_op = 2'd1; c.pc_write_cond = 1; c.pc_source = 2'd1; end
         S_JUMP:     begin c.pc_write = 1; c.pc_source = 2'd2; end
         S_JAL:      begin c.pc_write = 1; c.pc_source = 2'd2; c.reg_write = 1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2; end
         S_JR:       begin c.pc_write = 1; c.pc_source = 2'd3; end
         S_I_EXEC:   begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
         S_I_WB:     c.reg_write = 1;
         default:    ;
      endcase
      return c;
   endfunction

   function automatic ctl_t mask_rst(input ctl_t c);
      ctl_t m;
      m = c;
      m.pc_write = 0; m.pc_write_cond = 0; m.mem_read = 0; m.mem_write = 0;
      m.ir_write = 0; m.reg_write = 0; m.illegal_op = 0;
      return m;
   endfunction

   task automatic compare(input ctl_t exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s ctl observed=%h expected=%h", tag, obs, exp);
      end
      checks++;
      assert (instr_count === exp_count) else begin
         failures++;
         $error("FAIL %s instr_count observed=%0d expected=%0d", tag, instr_count, exp_count);
      end
   endtask

   // One clock in a given phase; entered and left at posedge+1.
   task automatic step(input int ph, input logic mr, input logic ill, input string tag);
      mem_ready = mr;
      @(negedge clk);
      compare(expect_ctl(ph, mr, ill), tag);
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fst,
                            input int mst, input string tag);
      int   ph[$];
      logic ill;
      op_code = op;
      funct   = fn;
      ill     = 1'b0;
      ph.push_back(S_FETCH);
      ph.push_back(S_DECODE);
      case (op)
         OP_LW:    begin ph.push_back(S_MEM_ADDR); ph.push_back(S_MEM_RD); ph.push_back(S_MEM_WB); end
         OP_SW:    begin ph.push_back(S_MEM_ADDR); ph.push_back(S_MEM_WR); end
         OP_RTYPE: begin
            if (fn == FUNCT_JR) ph.push_back(S_JR);
            else begin ph.push_back(S_EXEC_R); ph.push_back(S_R_WB); end
         end
         OP_BEQ:   ph.push_back(S_BRANCH);
         OP_J:     ph.push_back(S_JUMP);
         OP_JAL:   ph.push_back(S_JAL);
         OP_ADDI:  begin ph.push_back(S_I_EXEC); ph.push_back(S_I_WB); end
         default:  ill = 1'b1;
      endcase
      for (int i = 0; i < ph.size(); i++) begin
         if (ph[i] == S_FETCH || ph[i] == S_MEM_RD || ph[i] == S_MEM_WR) begin
            for (int k = 0; k < ((ph[i] == S_FETCH) ? fst : mst); k++)
               step(ph[i], 1'b0, ill, tag);
            step(ph[i], 1'b1, ill, tag);
         end else begin
            step(ph[i], 1'($urandom_range(0, 1)), ill, tag);
         end
      end
`ifdef INSTR_COUNT_EN
      if (!ill) exp_count = exp_count + 32'd1;
`endif
   endtask

   initial begin
      logic [5:0] illegal_tbl [4];
      logic [5:0] op, fn;
      illegal_tbl = '{6'h3F, 6'h01, 6'h05, 6'h20};
      exp_count = 32'h0;
      reset     = 1'b1;
      mem_ready = 1'b1;
      op_code   = 6'h00;
      funct     = 6'h00;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         compare(mask_rst(expect_ctl(S_FETCH, 1'b1, 1'b0)), "reset_hold");
         @(posedge clk);
         #1;
      end
      reset = 1'b0;

      run_instr(OP_LW,    6'h00, 0, 0, "lw");
      run_instr(OP_SW,    6'h00, 0, 3, "sw_stall");
      run_instr(OP_JAL,   6'h00, 0, 0, "jal");
      run_instr(OP_RTYPE, FUNCT_JR, 0, 0, "jr");
      run_instr(6'h3F,    6'h00, 0, 0, "illegal");
      run_instr(OP_RTYPE, 6'h20, 1, 0, "rtype");
      run_instr(OP_BEQ,   6'h00, 0, 0, "beq");
      run_instr(OP_ADDI,  6'h00, 0, 0, "addi");
      run_instr(OP_LW,    6'h00, 2, 2, "lw_stall");

      // Reset arriving while a store is stalled in MEM_WR.
      op_code = OP_SW;
      funct   = 6'h00;
      step(S_FETCH, 1'b1, 1'b0, "rst_wr");
      step(S_DECODE, 1'b1, 1'b0, "rst_wr");
      step(S_MEM_ADDR, 1'b0, 1'b0, "rst_wr");
      step(S_MEM_WR, 1'b0, 1'b0, "rst_wr");
      reset     = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
      compare(mask_rst(expect_ctl(S_MEM_WR, 1'b0, 1'b0)), "rst_in_wr");
      @(posedge clk);
      #1;
      reset     = 1'b0;
      exp_count = 32'h0;
      step(S_FETCH, 1'b0, 1'b0, "after_rst");
      step(S_FETCH, 1'b1, 1'b0, "after_rst");
      step(S_DECODE, 1'b0, 1'b0, "after_rst");
      step(S_MEM_ADDR, 1'b1, 1'b0, "after_rst");
      step(S_MEM_WR, 1'b1, 1'b0, "after_rst");
`ifdef INSTR_COUNT_EN
      exp_count = exp_count + 32'd1;
`endif

      for (int n = 0; n < 200; n++) begin
         fn = 6'($urandom_range(0, 63));
         case ($urandom_range(0, 8))
            0:       begin op = OP_RTYPE; if (fn == FUNCT_JR) fn = 6'h20; end
            1:       begin op = OP_RTYPE; fn = FUNCT_JR; end
            2:       op = OP_LW;
            3:       op = OP_SW;
            4:       op = OP_BEQ;
            5:       op = OP_J;
            6:       op = OP_JAL;
            7:       op = OP_ADDI;
            default: op = illegal_tbl[$urandom_range(0, 3)];
         endcase
         run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
